// File: rtl/y86_decode_regfile_sb.sv
// Y86-64 decode stage: register file with writeback bypass, source/destination
// selection, per-register pending-write scoreboard and a valid/ready E register.
module y86_decode_regfile_sb #(
  parameter int DATA_W = 64,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [3:0]        d_rA,
  input  logic [3:0]        d_rB,
  input  logic              d_cnd,
  input  logic [3:0]        wb_dstE,
  input  logic [3:0]        wb_dstM,
  input  logic [DATA_W-1:0] wb_valE,
  input  logic [DATA_W-1:0] wb_valM,
  output logic              e_valid,
  input  logic              e_ready,
  output logic [3:0]        e_icode,
  output logic [3:0]        e_ifun,
  output logic [3:0]        e_srcA,
  output logic [3:0]        e_srcB,
  output logic [3:0]        e_dstE,
  output logic [3:0]        e_dstM,
  output logic [DATA_W-1:0] e_valA,
  output logic [DATA_W-1:0] e_valB
);

  localparam int NREG = 15;
  localparam int CW   = PEND_W + 2;
  localparam logic [3:0]    R_NONE   = 4'hF;
  localparam logic [3:0]    R_RSP    = 4'h4;
  localparam logic [CW-1:0] PEND_MAX = CW'((1 << PEND_W) - 1);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0, I_NOP   = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ  = 4'h6, I_JXX    = 4'h7,
    I_CALL   = 4'h8, I_RET   = 4'h9, I_PUSHQ = 4'hA, I_POPQ   = 4'hB
  } icode_e;

  typedef struct packed {
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        src_a;
    logic [3:0]        src_b;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
  } e_stage_t;

  logic [DATA_W-1:0] rf_q   [NREG];
  logic [DATA_W-1:0] rf_d   [NREG];
  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic [CW-1:0]     base_c [NREG];
  logic [CW-1:0]     inc_c  [NREG];

  e_stage_t e_q, e_d;
  logic     e_valid_q, e_valid_d;

  logic [3:0] src_a, src_b, dst_e, dst_m;
  logic       hazard, saturate, accept;

  // Bypass order: M port, then E port, then the array; ID F reads as zero.
  function automatic logic [DATA_W-1:0] read_reg(input logic [3:0] id);
    if (id == R_NONE)       return '0;
    else if (id == wb_dstM) return wb_valM;
    else if (id == wb_dstE) return wb_valE;
    else                    return rf_q[id];
  endfunction

  // A pending source is safe only when this cycle's writebacks retire all of it.
  function automatic logic src_hazard(input logic [3:0] id);
    logic [CW-1:0] pend, hits;
    if (id == R_NONE) return 1'b0;
    pend = CW'(pend_q[id]);
    hits = CW'(wb_dstE == id) + CW'(wb_dstM == id);
    return (pend != '0) && (pend != hits);
  endfunction

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    src_a = R_NONE;
    src_b = R_NONE;
    dst_e = R_NONE;
    dst_m = R_NONE;
    case (d_icode)
      I_RRMOVQ: begin
        src_a = d_rA;
        if (d_ifun == 4'h0 || d_cnd) dst_e = d_rB;
      end
      I_IRMOVQ: dst_e = d_rB;
      I_RMMOVQ: begin src_a = d_rA;  src_b = d_rB;  end
      I_MRMOVQ: begin src_b = d_rB;  dst_m = d_rA;  end
      I_OPQ:    begin src_a = d_rA;  src_b = d_rB;  dst_e = d_rB;  end
      I_CALL:   begin src_b = R_RSP; dst_e = R_RSP; end
      I_RET:    begin src_a = R_RSP; src_b = R_RSP; dst_e = R_RSP; end
      I_PUSHQ:  begin src_a = d_rA;  src_b = R_RSP; dst_e = R_RSP; end
      I_POPQ:   begin src_a = R_RSP; src_b = R_RSP; dst_e = R_RSP; dst_m = d_rA; end
      default:  ;
    endcase
  end

  // Counter after this cycle's writebacks (clamped at zero) and the potential accept.
  always_comb begin
    saturate = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      inc_c[r]  = CW'(dst_e == 4'(r)) + CW'(dst_m == 4'(r));
      base_c[r] = CW'(pend_q[r]) - CW'(wb_dstE == 4'(r) && pend_q[r] != '0);
      base_c[r] = base_c[r] - CW'(wb_dstM == 4'(r) && base_c[r] != '0);
      if (inc_c[r] != '0 && (base_c[r] + inc_c[r]) > PEND_MAX) saturate = 1'b1;
    end
  end

  assign hazard  = src_hazard(src_a) | src_hazard(src_b);
  assign d_ready = (!e_valid_q || e_ready) && !hazard && !saturate;
  assign accept  = d_valid && d_ready;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_d[r] = accept ? PEND_W'(base_c[r] + inc_c[r]) : PEND_W'(base_c[r]);
    end
  end

  // Later assignment wins, so M overrides E on a shared destination.
  always_comb begin
    rf_d = rf_q;
    if (wb_dstE != R_NONE) rf_d[wb_dstE] = wb_valE;
    if (wb_dstM != R_NONE) rf_d[wb_dstM] = wb_valM;
  end

  always_comb begin
    e_d       = e_q;
    e_valid_d = e_valid_q;
    if (accept) begin
      e_d.icode = d_icode;
      e_d.ifun  = d_ifun;
      e_d.src_a = src_a;
      e_d.src_b = src_b;
      e_d.dst_e = dst_e;
      e_d.dst_m = dst_m;
      e_d.val_a = read_reg(src_a);
      e_d.val_b = read_reg(src_b);
      e_valid_d = 1'b1;
    end else if (e_valid_q && e_ready) begin
      e_valid_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the register file is reset like any other state; architectural registers start at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q      <= '{default: '0};
      pend_q    <= '{default: '0};
      e_valid_q <= 1'b0;
      e_q       <= '{icode: 4'h0, ifun: 4'h0, src_a: R_NONE, src_b: R_NONE,
                     dst_e: R_NONE, dst_m: R_NONE, val_a: '0, val_b: '0};
    end else begin
      rf_q      <= rf_d;
      pend_q    <= pend_d;
      e_valid_q <= e_valid_d;
      e_q       <= e_d;
    end
  end

  assign e_valid = e_valid_q;
  assign e_icode = e_q.icode;
  assign e_ifun  = e_q.ifun;
  assign e_srcA  = e_q.src_a;
  assign e_srcB  = e_q.src_b;
  assign e_dstE  = e_q.dst_e;
  assign e_dstM  = e_q.dst_m;
  assign e_valA  = e_q.val_a;
  assign e_valB  = e_q.val_b;

endmodule

// File: tb/tb_y86_decode_regfile_sb.sv
// Directed bench for y86_decode_regfile_sb: selection, bypass, scoreboard stalls,
// saturation, backpressure and asynchronous reset.
module tb_y86_decode_regfile_sb;

  localparam int DATA_W = 64;
  localparam logic [3:0] NONE = 4'hF;

  logic              clk = 1'b0;
  logic              clk_en = 1'b0;
  logic              rst;
  logic              d_valid, d_ready, d_cnd;
  logic [3:0]        d_icode, d_ifun, d_rA, d_rB;
  logic [3:0]        wb_dstE, wb_dstM;
  logic [DATA_W-1:0] wb_valE, wb_valM;
  logic              e_valid, e_ready;
  logic [3:0]        e_icode, e_ifun, e_srcA, e_srcB, e_dstE, e_dstM;
  logic [DATA_W-1:0] e_valA, e_valB;

  int n_pass  = 0;
  int n_total = 0;

  always #5 if (clk_en) clk = ~clk;

  y86_decode_regfile_sb #(.DATA_W(DATA_W), .PEND_W(2)) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB), .d_cnd(d_cnd),
    .wb_dstE(wb_dstE), .wb_dstM(wb_dstM), .wb_valE(wb_valE), .wb_valM(wb_valM),
    .e_valid(e_valid), .e_ready(e_ready),
    .e_icode(e_icode), .e_ifun(e_ifun), .e_srcA(e_srcA), .e_srcB(e_srcB),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .e_valA(e_valA), .e_valB(e_valB)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] icode, ifun, ra, rb, input logic cnd);
    d_valid = 1'b1;
    d_icode = icode;
    d_ifun  = ifun;
    d_rA    = ra;
    d_rB    = rb;
    d_cnd   = cnd;
  endtask

  task automatic idle();
    d_valid = 1'b0;
    d_icode = 4'h1;
    d_ifun  = 4'h0;
    d_rA    = NONE;
    d_rB    = NONE;
    d_cnd   = 1'b0;
  endtask

  task automatic wb(input logic [3:0] de, input logic [63:0] ve,
                    input logic [3:0] dm, input logic [63:0] vm);
    wb_dstE = de;
    wb_valE = ve;
    wb_dstM = dm;
    wb_valM = vm;
  endtask

  initial begin
    rst     = 1'b1;
    e_ready = 1'b1;
    idle();
    wb(NONE, '0, NONE, '0);
    #2 rst = 1'b0;
    #1;
    check("rst_e_valid", e_valid, 1'b0);
    check("rst_e_dstE",  e_dstE,  NONE);
    check("rst_e_srcA",  e_srcA,  NONE);
    check("rst_e_valA",  e_valA,  '0);
    check("rst_d_ready", d_ready, 1'b1);
    clk_en = 1'b1;

    // rrmovq r1 -> r2
    instr(4'h2, 4'h0, 4'h1, 4'h2, 1'b0);
    tick();
    check("rr_e_valid", e_valid, 1'b1);
    check("rr_e_valA",  e_valA,  '0);
    check("rr_e_dstE",  e_dstE,  4'h2);
    check("rr_e_dstM",  e_dstM,  NONE);
    check("rr_pend2",   dut.pend_q[2], 2'd1);

    // irmovq -> r3 leaves r3 pending
    instr(4'h3, 4'h0, NONE, 4'h3, 1'b0);
    tick();
    check("ir_pend3", dut.pend_q[3], 2'd1);

    // addq r3, r0 while r3's writeback arrives: bypass covers it
    instr(4'h6, 4'h0, 4'h3, 4'h0, 1'b0);
    wb(4'h3, 64'h1234, NONE, '0);
    #1 check("byp_d_ready", d_ready, 1'b1);
    tick();
    check("byp_e_valA", e_valA, 64'h1234);
    check("byp_e_srcA", e_srcA, 4'h3);
    check("byp_e_dstE", e_dstE, 4'h0);
    check("byp_pend3",  dut.pend_q[3], 2'd0);
    check("byp_pend0",  dut.pend_q[0], 2'd1);

    // next-cycle read of r3 comes from the array
    wb(NONE, '0, NONE, '0);
    instr(4'h2, 4'h0, 4'h3, NONE, 1'b0);
    tick();
    check("r3_read", e_valA, 64'h1234);
    check("r3_nodst", e_dstE, NONE);

    idle();
    wb(4'h2, 64'hAA, 4'h0, 64'hBB);
    tick();
    wb(NONE, '0, NONE, '0);
    check("clr_pend2", dut.pend_q[2], 2'd0);
    check("clr_pend0", dut.pend_q[0], 2'd0);

    // load-use: mrmovq -> r1 then addq r1, r6
    instr(4'h5, 4'h0, 4'h1, NONE, 1'b0);
    tick();
    check("lu_pend1", dut.pend_q[1], 2'd1);
    check("lu_dstM",  e_dstM, 4'h1);
    instr(4'h6, 4'h0, 4'h1, 4'h6, 1'b0);
    #1 check("lu_stall0", d_ready, 1'b0);
    tick();
    check("lu_stall1", d_ready, 1'b0);
    wb(NONE, '0, 4'h1, 64'hDEAD_BEEF);
    #1 check("lu_release", d_ready, 1'b1);
    tick();
    wb(NONE, '0, NONE, '0);
    check("lu_e_valA",  e_valA,  64'hDEAD_BEEF);
    check("lu_e_valB",  e_valB,  '0);
    check("lu_e_icode", e_icode, 4'h6);
    check("lu_pend1_0", dut.pend_q[1], 2'd0);
    check("lu_pend6",   dut.pend_q[6], 2'd1);

    // both ports hit r5: M wins for bypass and array
    instr(4'h2, 4'h0, 4'h5, NONE, 1'b0);
    wb(4'h5, 64'h1, 4'h5, 64'h2);
    tick();
    check("pc_bypass", e_valA, 64'h2);
    wb(NONE, '0, NONE, '0);
    tick();
    check("pc_array", e_valA, 64'h2);

    // cmovXX not taken / taken
    instr(4'h2, 4'h3, 4'h1, 4'h7, 1'b0);
    tick();
    check("cmov_nt_dstE", e_dstE, NONE);
    check("cmov_nt_valA", e_valA, 64'hDEAD_BEEF);
    check("cmov_nt_pend", dut.pend_q[7], 2'd0);
    instr(4'h2, 4'h3, 4'h1, 4'h7, 1'b1);
    tick();
    check("cmov_t_dstE", e_dstE, 4'h7);
    check("cmov_t_pend", dut.pend_q[7], 2'd1);

    // popq with rA = RSP: +2 on r4, both writebacks retire it
    instr(4'hB, 4'h0, 4'h4, NONE, 1'b0);
    tick();
    check("pop_srcA", e_srcA, 4'h4);
    check("pop_dstE", e_dstE, 4'h4);
    check("pop_dstM", e_dstM, 4'h4);
    check("pop_pend4", dut.pend_q[4], 2'd2);
    idle();
    wb(4'h4, 64'h10, 4'h4, 64'h20);
    tick();
    wb(NONE, '0, NONE, '0);
    check("pop_pend4_0", dut.pend_q[4], 2'd0);

    // saturation: three in-flight writes to r8 fill a 2-bit counter
    for (int i = 0; i < 3; i++) begin
      instr(4'h3, 4'h0, NONE, 4'h8, 1'b0);
      #1 check("sat_fill_ready", d_ready, 1'b1);
      tick();
    end
    check("sat_pend8", dut.pend_q[8], 2'd3);
    #1 check("sat_stall", d_ready, 1'b0);
    idle();
    tick();
    check("sat_no_acc", dut.pend_q[8], 2'd3);

    // backpressure: X held in E while Y waits, then Y and Z one per cycle
    e_ready = 1'b0;
    instr(4'h3, 4'h0, NONE, 4'h9, 1'b0);
    #1 check("bp_x_ready", d_ready, 1'b1);
    tick();
    check("bp_x_valid", e_valid, 1'b1);
    instr(4'h3, 4'h0, NONE, 4'hA, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_stall", d_ready, 1'b0);
      tick();
      check("bp_hold_dstE",  e_dstE,  4'h9);
      check("bp_hold_valid", e_valid, 1'b1);
    end
    e_ready = 1'b1;
    #1 check("bp_release", d_ready, 1'b1);
    tick();
    check("bp_y_dstE", e_dstE, 4'hA);
    instr(4'h3, 4'h0, NONE, 4'hB, 1'b0);
    tick();
    check("bp_z_dstE", e_dstE, 4'hB);
    idle();
    tick();
    check("bp_drain_valid", e_valid, 1'b0);
    check("bp_drain_hold",  e_dstE,  4'hB);
    check("bp_pend9",  dut.pend_q[9],  2'd1);
    check("bp_pend10", dut.pend_q[10], 2'd1);
    check("bp_pend11", dut.pend_q[11], 2'd1);

    // reset between clock edges takes effect immediately
    instr(4'h3, 4'h0, NONE, 4'h9, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    check("ar_e_valid", e_valid, 1'b0);
    check("ar_e_dstE",  e_dstE,  NONE);
    check("ar_pend9",   dut.pend_q[9], 2'd0);
    check("ar_pend8",   dut.pend_q[8], 2'd0);
    check("ar_r3",      dut.rf_q[3],   '0);
    rst = 1'b0;
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
